// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding, bus mode constant and divider sizing.
// Purely declarative; no logic of its own.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_e;

    // {CPOL, CPHA}: mode 0 idles SCLK low and samples on the rising edge.
    localparam logic [1:0] SPI_MODE = 2'b00;
    localparam logic       SPI_CPOL = SPI_MODE[1];

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: CLKDIV cycles per phase, strobes on the last cycle of each phase.
// Strobes are combinational from the counter; i_clear restarts a low phase on the next cycle.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLKDIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_phase,
    output logic o_phase_end,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned     CW     = cnt_width(CLKDIV);
    localparam logic [CW-1:0]   RELOAD = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (i_clear) begin
            cnt_d   = RELOAD;
            phase_d = 1'b0;
        end else if (i_en) begin
            if (cnt_q == '0) begin
                cnt_d   = RELOAD;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign o_phase     = phase_q;
    assign o_phase_end = i_en && (cnt_q == '0);
    assign o_rise      = o_phase_end && !phase_q;
    assign o_fall      = o_phase_end && phase_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: pops FWFT FIFO words and shifts them out MSB-first, CS held low across a burst.
// Pop is combinational on the FIFO head; optional receive path under SPI_MASTER_RX_EN.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CLKDIV = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_rd,
    output logic             o_sclk,
    output logic             o_mosi,
    output logic             o_cs_n,
    output logic             o_busy,
`ifdef SPI_MASTER_RX_EN
    input  logic             i_miso,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
`endif
    output logic             o_byte_done
);

    localparam int unsigned   BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    spi_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             fifo_rd, byte_done;

    logic div_clear, div_phase, div_phase_end, div_rise, div_fall;

    spi_clk_div #(.CLKDIV(CLKDIV)) u_clk_div (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_en        (state_q != IDLE),
        .i_clear     (div_clear),
        .o_phase     (div_phase),
        .o_phase_end (div_phase_end),
        .o_rise      (div_rise),
        .o_fall      (div_fall)
    );

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        fifo_rd   = 1'b0;
        byte_done = 1'b0;
        div_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_clear = 1'b1;
                if (!i_fifo_empty) begin
                    fifo_rd = 1'b1;
                    shreg_d = i_fifo_data;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_fall) begin
                    if (bit_q == LAST_BIT) begin
                        byte_done = 1'b1;
                        // Chain the next word with no gap so the burst stays one frame.
                        if (!i_fifo_empty) begin
                            fifo_rd = 1'b1;
                            shreg_d = i_fifo_data;
                            bit_d   = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            HOLD: begin
                if (div_phase_end) begin
                    state_d   = IDLE;
                    div_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_reset) begin
            fifo_rd   = 1'b0;
            byte_done = 1'b0;
            div_clear = 1'b1;
        end
    end

    assign mosi_d = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
    assign cs_n_d = (state_d == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shreg_q <= '0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign o_fifo_rd   = fifo_rd;
    assign o_byte_done = byte_done;
    assign o_sclk      = div_phase ^ SPI_CPOL;
    assign o_mosi      = mosi_q;
    assign o_cs_n      = cs_n_q;
    assign o_busy      = (state_q != IDLE);

`ifdef SPI_MASTER_RX_EN
    logic [WIDTH-1:0] rx_sh_q, rx_data_q;
    logic             rx_valid_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if ((state_q == SHIFT) && div_rise) begin
                rx_sh_q <= (rx_sh_q << 1) | WIDTH'(i_miso);
            end
            rx_valid_q <= byte_done;
            if (byte_done) begin
                rx_data_q <= rx_sh_q;
            end
        end
    end

    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
`else
    logic unused_rise;
    assign unused_rise = div_rise;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with a cycle-level frame model and literal timing checks.
module tb_spi_master_tx;

    localparam int W        = 8;
    localparam int C        = 2;
    localparam int WORD_CYC = 2 * W * C;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_fifo_empty;
    logic [W-1:0] i_fifo_data;
    logic         o_fifo_rd, o_sclk, o_mosi, o_cs_n, o_busy, o_byte_done;
`ifdef SPI_MASTER_RX_EN
    logic         i_miso;
    logic [W-1:0] o_rx_data;
    logic         o_rx_valid;
    assign i_miso = o_mosi;
`endif

    spi_master_tx #(.WIDTH(W), .CLKDIV(C)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_rd    (o_fifo_rd),
        .o_sclk       (o_sclk),
        .o_mosi       (o_mosi),
        .o_cs_n       (o_cs_n),
        .o_busy       (o_busy),
`ifdef SPI_MASTER_RX_EN
        .i_miso       (i_miso),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
`endif
        .o_byte_done  (o_byte_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] fq[$];
    int           rd_cyc[$], bd_cyc[$], rise_cyc[$], csup_cyc[$], rxv_cyc[$];
    logic         rise_bits[$];
    logic [W-1:0] rx_word;
    int           activity;
    bit           chk_en = 1'b0;
    logic         prev_sclk = 1'b0;
    logic         prev_cs_n = 1'b1;

    // Frame model: 0 = idle, 1 = shifting a word, 2 = CS hold after the last word.
    int           m_st  = 0;
    int           m_pos = 0;
    logic [W-1:0] m_word = '0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_check();
        int   bitn, ph;
        logic last;
        if (i_reset) begin
            chk1("rd_in_reset", o_fifo_rd, 1'b0);
            if (m_st == 0) begin
                chk1("rst_cs_n", o_cs_n, 1'b1);
                chk1("rst_sclk", o_sclk, 1'b0);
                chk1("rst_busy", o_busy, 1'b0);
                chk1("rst_done", o_byte_done, 1'b0);
            end
            m_st = 0;
        end else if (m_st == 0) begin
            chk1("idle_cs_n", o_cs_n, 1'b1);
            chk1("idle_sclk", o_sclk, 1'b0);
            chk1("idle_busy", o_busy, 1'b0);
            chk1("idle_done", o_byte_done, 1'b0);
            chk1("idle_rd", o_fifo_rd, !i_fifo_empty);
            if (!i_fifo_empty) begin
                m_st   = 1;
                m_pos  = 0;
                m_word = i_fifo_data;
            end
        end else if (m_st == 1) begin
            bitn = m_pos / (2 * C);
            ph   = m_pos % (2 * C);
            last = (m_pos == WORD_CYC - 1);
            chk1("word_cs_n", o_cs_n, 1'b0);
            chk1("word_busy", o_busy, 1'b1);
            chk1("word_sclk", o_sclk, ph >= C);
            chk1("word_mosi", o_mosi, m_word[W-1-bitn]);
            chk1("word_done", o_byte_done, last);
            chk1("word_rd", o_fifo_rd, last && !i_fifo_empty);
            if (last) begin
                m_pos = 0;
                if (!i_fifo_empty) m_word = i_fifo_data;
                else m_st = 2;
            end else begin
                m_pos++;
            end
        end else begin
            chk1("hold_cs_n", o_cs_n, 1'b0);
            chk1("hold_sclk", o_sclk, 1'b0);
            chk1("hold_busy", o_busy, 1'b1);
            chk1("hold_done", o_byte_done, 1'b0);
            chk1("hold_rd", o_fifo_rd, 1'b0);
            if (m_pos == C - 1) m_st = 0;
            else m_pos++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (o_fifo_rd) rd_cyc.push_back(cyc);
            if (o_byte_done) bd_cyc.push_back(cyc);
            if (o_sclk && !prev_sclk) begin
                rise_cyc.push_back(cyc);
                rise_bits.push_back(o_mosi);
            end
            if (o_cs_n && !prev_cs_n) csup_cyc.push_back(cyc);
            if (o_fifo_rd || !o_cs_n || o_sclk || o_busy) activity++;
`ifdef SPI_MASTER_RX_EN
            if (o_rx_valid) begin
                rxv_cyc.push_back(cyc);
                rx_word = o_rx_data;
            end
`endif
            model_check();
        end
        prev_sclk = o_sclk;
        prev_cs_n = o_cs_n;
        if (o_fifo_rd && fq.size() > 0) fq.delete(0);
    end

    task automatic apply_fifo();
        i_fifo_empty = (fq.size() == 0);
        i_fifo_data  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        apply_fifo();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_fifo();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        bd_cyc.delete();
        rise_cyc.delete();
        csup_cyc.delete();
        rxv_cyc.delete();
        rise_bits.delete();
        activity = 0;
    endtask

    function automatic int pack_bits();
        int v = 0;
        foreach (rise_bits[i]) v = (v << 1) | int'(rise_bits[i]);
        return v;
    endfunction

    initial begin
        i_reset      = 1'b1;
        i_fifo_empty = 1'b1;
        i_fifo_data  = '0;
        rx_word      = '0;
        activity     = 0;
        chk_en       = 1'b1;
        run(2);
        chk1("reset_cs_n", o_cs_n, 1'b1);
        chk1("reset_sclk", o_sclk, 1'b0);
        chk1("reset_mosi", o_mosi, 1'b0);
        chk1("reset_busy", o_busy, 1'b0);
        chk1("reset_done", o_byte_done, 1'b0);
        chk1("reset_rd", o_fifo_rd, 1'b0);
        i_reset = 1'b0;
        run(2);

        // Single word 0xA5
        clear_logs();
        push(8'hA5);
        run(45);
        chkn("t1_pops", rd_cyc.size(), 1);
        chkn("t1_rises", rise_cyc.size(), 8);
        chkn("t1_bits", pack_bits(), 32'hA5);
        chkn("t1_first_rise", rise_cyc[0] - rd_cyc[0], 3);
        chkn("t1_sclk_period", rise_cyc[1] - rise_cyc[0], 4);
        chkn("t1_byte_done", bd_cyc[0] - rd_cyc[0], 32);
        chkn("t1_cs_high", csup_cyc[0] - rd_cyc[0], 35);

        // Burst of three preloaded words
        clear_logs();
        push(8'h12);
        push(8'h34);
        push(8'h56);
        run(3 * WORD_CYC + 10);
        chkn("t2_pops", rd_cyc.size(), 3);
        chkn("t2_rises", rise_cyc.size(), 24);
        chkn("t2_bits", pack_bits(), 32'h123456);
        chkn("t2_pop1", rd_cyc[1] - rd_cyc[0], 32);
        chkn("t2_pop2", rd_cyc[2] - rd_cyc[0], 64);
        chkn("t2_pop1_done", bd_cyc[0], rd_cyc[1]);
        chkn("t2_pop2_done", bd_cyc[1], rd_cyc[2]);
        chkn("t2_contig", rise_cyc[23] - rise_cyc[0], 92);
        chkn("t2_cs_rises", csup_cyc.size(), 1);
        chkn("t2_cs_high", csup_cyc[0] - rd_cyc[0], 99);

        // Empty FIFO stays quiet
        clear_logs();
        run(100);
        chkn("t3_activity", activity, 0);
        chkn("t3_pops", rd_cyc.size(), 0);

        // Reset at frame cycle 10, then 0x3C
        clear_logs();
        push(8'hFF);
        run(10);
        i_reset = 1'b1;
        push(8'h3C);
        step();
        chk1("t4_cs_n", o_cs_n, 1'b1);
        chk1("t4_sclk", o_sclk, 1'b0);
        chk1("t4_mosi", o_mosi, 1'b0);
        chk1("t4_busy", o_busy, 1'b0);
        step();
        i_reset = 1'b0;
        run(45);
        chkn("t4_pops", rd_cyc.size(), 2);
        chkn("t4_pop_gap", rd_cyc[1] - rd_cyc[0], 12);
        chkn("t4_bits", pack_bits(), 32'h33C);

        // Word arrives during CS hold
        clear_logs();
        push(8'h5A);
        run(33);
        push(8'h81);
        run(45);
        chkn("t5_pops", rd_cyc.size(), 2);
        chkn("t5_pop_gap", rd_cyc[1] - rd_cyc[0], 35);
        chkn("t5_cs_high", csup_cyc[0] - rd_cyc[0], 35);
        chkn("t5_bits", pack_bits(), 32'h5A81);

`ifdef SPI_MASTER_RX_EN
        clear_logs();
        push(8'hC3);
        run(45);
        chkn("t6_rx_pulses", rxv_cyc.size(), 1);
        chkn("t6_rx_cycle", rxv_cyc[0] - rd_cyc[0], 33);
        chkn("t6_rx_data", int'(rx_word), 32'hC3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Downstream consumer of the byte FIFO. Pops words from the FIFO's first-word-fall-through read port and serialises them MSB-first onto an SPI mode-0 master bus.
- SCLK is derived from i_clk by an integer divider.
- CS_n stays low across back-to-back words while the FIFO keeps data, so a burst goes out as one frame.

Parameters:
- WIDTH, 8: bits per word; must equal the FIFO data width.
- CLKDIV, 2: SCLK half-period in i_clk cycles; minimum 1.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_fifo_empty  in  1  FIFO has no valid word (tie to FIFO will_underflow)
- i_fifo_data  in  WIDTH  FIFO head word, valid when !i_fifo_empty
- o_fifo_rd  out  1  pop strobe (FIFO i_rd); combinational
- o_sclk  out  1  SPI clock, idle low
- o_mosi  out  1  SPI data out
- o_cs_n  out  1  chip select, active-low
- o_busy  out  1  frame in progress (state != IDLE)
- o_byte_done  out  1  one-cycle pulse in the last cycle of each word

Behaviour:
- Single clock domain: i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: state IDLE, o_cs_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_byte_done=0. o_fifo_rd is forced to 0 while i_reset is high.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - If !i_fifo_empty: o_fifo_rd=1 that cycle, shift register loads i_fifo_data, and the next state is SHIFT.
  - IDLE always lasts at least 1 cycle with o_cs_n=1.
- SHIFT, per bit:
  - Low phase: CLKDIV cycles with o_sclk=0.
  - High phase: CLKDIV cycles with o_sclk=1.
  - o_mosi = current MSB of the shift register, valid from the first low-phase cycle.
  - Shift register advances one bit when the high phase ends.
  - Divider counter is $clog2(CLKDIV)-wide (minimum 1 bit) and counts CLKDIV-1 down to 0. Bit counter runs 0..WIDTH-1.
- Timing:
  - Pop in cycle 0 puts o_cs_n=0 and the first low phase in cycle 1; the first rising SCLK edge is at cycle 1+CLKDIV.
  - One word occupies 2*WIDTH*CLKDIV cycles of SHIFT.
- Last cycle of a word (bit WIDTH-1, high phase, count 0):
  - o_byte_done=1.
  - If !i_fifo_empty: o_fifo_rd=1, load the new word, stay in SHIFT. The next cycle starts its low phase with no gap and o_cs_n stays 0.
  - Else: go to HOLD.
- HOLD: CLKDIV cycles with o_sclk=0 and o_cs_n=0 (CS hold time), then IDLE.
  - The FIFO becoming non-empty during HOLD does not extend the frame; the next word starts a new frame via IDLE.
- o_fifo_rd is asserted only when i_fifo_empty=0. It is never asserted on two consecutive cycles.
- Reset mid-frame: outputs return to reset values on the next edge. A partially sent word is discarded and not re-popped.
- o_sclk, o_mosi and o_cs_n are registered (no glitches).

Optional Feature:
- Macro SPI_MASTER_RX_EN.
- When defined, the block adds:
  - ports i_miso (in, 1), o_rx_data (out, WIDTH) and o_rx_valid (out, 1);
  - an RX shift register that samples i_miso on each o_sclk rising edge (the cycle o_sclk goes 0->1), MSB first;
  - o_rx_valid: one-cycle pulse in the cycle after o_byte_done, with o_rx_data holding the received word;
  - o_rx_data resets to 0 and holds until the next word completes.
- When not defined: none of these ports or registers exist, and TX behaviour is identical.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE=0, SHIFT=1, HOLD=2);
  - the CPOL/CPHA mode constant (mode 0);
  - a function computing the divider counter width.
- One natural sub-module: spi_clk_div. It holds the CLKDIV half-period counter and outputs phase-end and edge strobes.

Test Plan:
- Single word, WIDTH=8, CLKDIV=2, FIFO holds 0xA5:
  - one o_fifo_rd pulse and o_cs_n low from cycle 1;
  - 8 SCLK pulses with period 4 cycles;
  - MOSI sampled at rising edges = 1,0,1,0,0,1,0,1;
  - o_byte_done at cycle 32; o_cs_n high at cycle 35.
- Burst 0x12,0x34,0x56 preloaded:
  - exactly 3 pops and 24 contiguous SCLK pulses;
  - o_cs_n continuously low;
  - pops coincide with o_byte_done cycles 32 and 64.
- FIFO empty for 100 cycles: o_fifo_rd=0, o_cs_n=1, o_sclk=0, o_busy=0 throughout.
- Assert i_reset at cycle 10 of a frame: next cycle o_cs_n=1, o_sclk=0, o_mosi=0, no extra pop; a subsequent word 0x3C transmits correctly.
- Word pushed during HOLD: frame ends (o_cs_n high for at least 1 cycle), then a new frame starts with its own pop.
- SPI_MASTER_RX_EN defined, i_miso looped to o_mosi, send 0xC3: o_rx_valid pulses once, at cycle 33, with o_rx_data=0xC3.
